ifetch_queue: RTL and testbench
===============================

# ifetch_queue

Instruction prefetch queue between the instruction ROM and the asca16core decode stage. It issues sequential ROM reads, buffers the returned opcodes with their addresses, and presents one opcode per cycle to the core under a valid/ready handshake. A branch redirect from the branch controller flushes the queue and restarts fetch at the target.

## Interface
- DEPTH, 4: queue entries (power of two, 2..16).
- AW, 16: address width.
- DW, 16: opcode width.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- fetch_en  in  1  allows new ROM reads; the ROM-side enable.
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  AW  ROM read address.
- rom_data  in  DW  ROM read data, valid the cycle after rom_rd.
- redirect  in  1  branch taken; single-cycle pulse.
- redirect_addr  in  AW  branch target, valid with redirect.
- op_valid  out  1  head entry available.
- op  out  DW  head opcode; 16'h0000 when op_valid=0.
- op_pc  out  AW  address of head opcode; 16'h0000 when op_valid=0.
- op_ready  in  1  core accepts head; low while the core stalls (nop_en).

## Operation
- State:
  - fetch_pc (AW), reset 0.
  - FIFO storage {pc, opcode} x DEPTH, with rd_ptr, wr_ptr and count (0..DEPTH).
  - In-flight tracker rd_q plus pc_q; at most 1 read is in flight.
- Issue: rom_rd = fetch_en & ~redirect & ~reset & (count + rd_q < DEPTH).
  - rom_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc + 1, wrapping 16'hFFFF -> 16'h0000.
  - On issue: rd_q <= 1 and pc_q <= fetch_pc; otherwise rd_q <= 0.
- Return: in a cycle with rd_q=1 and no redirect, {pc_q, rom_data} is written at wr_ptr.
  - Credit reservation at issue guarantees a free slot, so overflow cannot occur.
- Pop: op_valid = (count != 0) & ~redirect. A pop occurs when op_valid & op_ready, and advances rd_ptr.
- Count update: +1 on push, -1 on pop, unchanged when push and pop coincide (including when count=DEPTH-1 or DEPTH).
- Pointer wrap: pointers wrap modulo DEPTH.
- Redirect has priority over all other actions in the same cycle:
  - count, rd_ptr and wr_ptr <= 0.
  - rd_q <= 0; any return arriving in the next cycle is discarded.
  - fetch_pc <= redirect_addr.
  - No issue and no pop occur.
- fetch_en low: no new issues. An in-flight read still returns and is pushed, and the queue drains normally.
- Reset (including mid-operation): after the edge, all state listed above is at its reset value and rom_rd, op_valid, op and op_pc are 0. An in-flight return is dropped.

## Timing
- ROM latency is fixed at 1 cycle.
- Queue write-to-output latency is 1 cycle: an entry pushed at the edge ending cycle N is visible in cycle N+1.
- First opcode after reset release, with fetch_en=1 in cycle 0:
  - rom_rd=1 with rom_addr=0 in cycle 0.
  - Data is returned in cycle 1.
  - op_valid=1, op_pc=0 in cycle 2.
- Redirect pulse in cycle T:
  - rom_rd=0 in cycle T.
  - rom_rd=1 with rom_addr=redirect_addr in cycle T+1.
  - op_valid=1, op_pc=redirect_addr in cycle T+3.
- Steady state with op_ready=1: one opcode per cycle, because count + rd_q stays below DEPTH.
- op_ready=0: the queue fills to DEPTH, then rom_rd stays 0. The cycle after op_ready rises:
  - count = DEPTH-1 < DEPTH, so rom_rd returns high.
  - The pop stream is uninterrupted.
- Combinational paths:
  - redirect to op_valid and redirect to rom_rd.
  - op_ready affects only the next state.

## Test plan
- Reset/startup: ROM holds word = address, fetch_en=1 and op_ready=1 from cycle 0 -> op_valid rises in cycle 2; op_pc/op go 0000, 0001, 0002 on consecutive cycles.
- Backpressure: hold op_ready=0 for 10 cycles -> count=4 and rom_rd=0. Release -> ops continue with no gap, duplicate or skip.
- Redirect: pulse redirect with redirect_addr=16'h0040 while count=3 and a read is in flight -> op_valid=0 in T+1 and T+2; the first op after the redirect has op_pc=0040; no stale entry appears.
- Wrap: redirect to 16'hFFFE -> op_pc sequence FFFE, FFFF, 0000, 0001.
- fetch_en toggling: drop fetch_en for 3 cycles mid-stream -> the in-flight word is delivered, the queue drains, and the sequence resumes at the next address.
- Reset mid-run: assert reset for 1 cycle with count=2 -> op_valid=0 the next cycle; the fetch sequence restarts at address 0.

Source files
------------

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction prefetch queue between the instruction ROM and the
// asca16core decode stage. Issues sequential ROM reads with a one-read-in-flight
// credit scheme, buffers {pc, opcode} pairs, and hands them to the core under a
// valid/ready handshake. A branch redirect flushes everything and restarts fetch.
module ifetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          fetch_en,
    output logic          rom_rd,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_addr,
    output logic          op_valid,
    output logic [DW-1:0] op,
    output logic [AW-1:0] op_pc,
    input  logic          op_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [AW-1:0] pc_mem [DEPTH];
    logic [DW-1:0] op_mem [DEPTH];

    logic [AW-1:0] fetch_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          rd_q;
    logic [AW-1:0] pc_q;

    logic          push;
    logic          pop;
    logic [CW-1:0] reserved;

    // A slot is reserved for the in-flight read, so issuing only while
    // count + rd_q < DEPTH guarantees the return always has somewhere to land.
    always_comb begin
        reserved = count + CW'(rd_q);
        rom_rd   = fetch_en & ~redirect & ~reset & (reserved < CW'(DEPTH));
        rom_addr = fetch_pc;
        push     = rd_q & ~redirect;
        op_valid = (count != '0) & ~redirect;
        pop      = op_valid & op_ready;
        op       = '0;
        op_pc    = '0;
        if (op_valid) begin
            op    = op_mem[rd_ptr];
            op_pc = pc_mem[rd_ptr];
        end
    end

    // Control state: reset clears everything, redirect flushes and retargets
    // fetch, otherwise issue/return/pop advance the pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rd_q     <= 1'b0;
            pc_q     <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_addr;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            rd_q     <= 1'b0;
        end else begin
            rd_q <= rom_rd;
            if (rom_rd) begin
                fetch_pc <= fetch_pc + AW'(1);
                pc_q     <= fetch_pc;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: the returning opcode is written alongside the address it
    // was fetched from; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (push & ~reset) begin
            pc_mem[wr_ptr] <= pc_q;
            op_mem[wr_ptr] <= rom_data;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed test of ifetch_queue. The ROM model returns
// address ^ 16'hA5A5 one cycle after each read, so every op can be checked
// against its op_pc. Each cycle: drive inputs after the edge, check outputs,
// then advance to the next edge.
module tb_ifetch_queue;

    logic        clk;
    logic        reset;
    logic        fetch_en;
    logic        rom_rd;
    logic [15:0] rom_addr;
    logic [15:0] rom_data;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        op_valid;
    logic [15:0] op;
    logic [15:0] op_pc;
    logic        op_ready;

    int checks;
    int errors;

    ifetch_queue #(.DEPTH(4), .AW(16), .DW(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .fetch_en      (fetch_en),
        .rom_rd        (rom_rd),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .op_valid      (op_valid),
        .op            (op),
        .op_pc         (op_pc),
        .op_ready      (op_ready)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // One-cycle-latency ROM whose contents are a scrambled copy of the address.
    always @(posedge clk) begin
        if (rom_rd) rom_data <= rom_addr ^ 16'hA5A5;
    end

    task automatic applyStimulus(input logic fe, input logic rdy, input logic redir,
                                 input logic [15:0] raddr, input logic rst);
        fetch_en      = fe;
        op_ready      = rdy;
        redirect      = redir;
        redirect_addr = raddr;
        reset         = rst;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic chk_op, input logic exp_valid,
                               input logic [15:0] exp_pc, input logic exp_rd,
                               input logic [15:0] exp_addr);
        logic [15:0] exp_op;
        logic [15:0] exp_opc;
        exp_op  = exp_valid ? (exp_pc ^ 16'hA5A5) : 16'h0000;
        exp_opc = exp_valid ? exp_pc : 16'h0000;
        if (chk_op) begin
            checks++;
            assert (op_valid === exp_valid) else begin
                errors++;
                $error("[TB] FAIL %s op_valid: got %b expected %b", tag, op_valid, exp_valid);
            end
            checks++;
            assert (op_pc === exp_opc) else begin
                errors++;
                $error("[TB] FAIL %s op_pc: got %h expected %h", tag, op_pc, exp_opc);
            end
            checks++;
            assert (op === exp_op) else begin
                errors++;
                $error("[TB] FAIL %s op: got %h expected %h", tag, op, exp_op);
            end
        end
        checks++;
        assert (rom_rd === exp_rd) else begin
            errors++;
            $error("[TB] FAIL %s rom_rd: got %b expected %b", tag, rom_rd, exp_rd);
        end
        if (exp_rd) begin
            checks++;
            assert (rom_addr === exp_addr) else begin
                errors++;
                $error("[TB] FAIL %s rom_addr: got %h expected %h", tag, rom_addr, exp_addr);
            end
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence; comments give the expected queue contents.
    initial begin
        clk      = 1'b0;
        rom_data = 16'h0000;
        checks   = 0;
        errors   = 0;
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        nextCycle();
        nextCycle();
        checkOutput("reset_hold", 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);

        // Startup: first op appears two cycles after reset release.
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("start_c0", 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000);
        nextCycle();
        checkOutput("start_c1", 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001);
        nextCycle();
        checkOutput("start_c2", 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0002);
        nextCycle();
        checkOutput("start_c3", 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0003);
        nextCycle();
        checkOutput("start_c4", 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0004);
        nextCycle();

        // Backpressure for 10 cycles: queue fills with 3,4,5,6 and fetch stops.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("bp_c5", 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0005);
        nextCycle();
        checkOutput("bp_c6", 1'b1, 1'b1, 16'h0003, 1'b1, 16'h0006);
        nextCycle();
        for (int i = 0; i < 8; i++) begin
            checkOutput("bp_full", 1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000);
            nextCycle();
        end

        // Release: count=4 so no issue this cycle, then fetch resumes at 7.
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("rel_c15", 1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000);
        nextCycle();
        checkOutput("rel_c16", 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0007);
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            checkOutput("rel_stream", 1'b1, 1'b1, 16'(5 + i), 1'b1, 16'(8 + i));
            nextCycle();
        end

        // One stalled cycle brings count to 3 with read 12 in flight.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("pre_redir", 1'b1, 1'b1, 16'h0009, 1'b1, 16'h000C);
        nextCycle();

        // Redirect to 0040: stale entries and the in-flight 12 are discarded.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'h0040, 1'b0);
        checkOutput("redir_T", 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("redir_T1", 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0040);
        nextCycle();
        checkOutput("redir_T2", 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0041);
        nextCycle();
        for (int i = 0; i < 3; i++) begin
            checkOutput("redir_stream", 1'b1, 1'b1, 16'(16'h0040 + i), 1'b1, 16'(16'h0042 + i));
            nextCycle();
        end

        // Redirect near the top of the address space to exercise fetch_pc wrap.
        applyStimulus(1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0);
        checkOutput("wrap_T", 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("wrap_T1", 1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFE);
        nextCycle();
        checkOutput("wrap_T2", 1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFF);
        nextCycle();
        checkOutput("wrap_FFFE", 1'b1, 1'b1, 16'hFFFE, 1'b1, 16'h0000);
        nextCycle();
        checkOutput("wrap_FFFF", 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'h0001);
        nextCycle();
        checkOutput("wrap_0000", 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0002);
        nextCycle();
        checkOutput("wrap_0001", 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0003);
        nextCycle();

        // fetch_en low for 3 cycles: in-flight 3 still delivered, queue drains.
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("fe_off0", 1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000);
        nextCycle();
        checkOutput("fe_off1", 1'b1, 1'b1, 16'h0003, 1'b0, 16'h0000);
        nextCycle();
        checkOutput("fe_off2", 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("fe_on0", 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004);
        nextCycle();
        checkOutput("fe_on1", 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0005);
        nextCycle();
        checkOutput("fe_on2", 1'b1, 1'b1, 16'h0004, 1'b1, 16'h0006);
        nextCycle();
        checkOutput("fe_on3", 1'b1, 1'b1, 16'h0005, 1'b1, 16'h0007);
        nextCycle();

        // Stall once so the queue holds two entries, then reset mid-run.
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("pre_rst", 1'b1, 1'b1, 16'h0006, 1'b1, 16'h0008);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
        checkOutput("rst_cycle", 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        checkOutput("rst_c0", 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000);
        nextCycle();
        checkOutput("rst_c1", 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0001);
        nextCycle();
        checkOutput("rst_c2", 1'b1, 1'b1, 16'h0000, 1'b1, 16'h0002);
        nextCycle();
        checkOutput("rst_c3", 1'b1, 1'b1, 16'h0001, 1'b1, 16'h0003);
        nextCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
